clk_gate_ctrl: RTL

- Idle-driven clock-gate controller running on the free-running (ungated) clock.
- Drives the enable of the downstream clock-gating cell that produces a subsystem's gated clock.
- Counts consecutive idle cycles, gates after a programmable threshold, and reopens the clock on busy, force or an explicit wake request.
- Acknowledges a wake request only after a fixed settle period.

---
 rtl/clk_gate_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clk_gate_ctrl
//
// Idle-driven clock-gate controller. Runs on the free-running clock and drives
// the enable of the downstream clock-gating cell for one subsystem. It counts
// consecutive idle cycles, gates the clock once a programmable threshold has
// been exceeded, and reopens the clock on busy, force, disabled auto-gating or
// an explicit wake request. A wake request is acknowledged only after a fixed
// settle period has elapsed with the clock running again.
//
// Parameters:
//   IdleCntWidth  width of the idle counter and of cfg_idle_thr_i
//   WakeCycles    cycles spent in WAKE (clock enabled) before RUN, 1..255
//   GateCntWidth  width of the saturating gate-event counter
//
// Ports:
//   clk_i           in   free-running clock
//   rst_ni          in   synchronous reset, active-low
//   cfg_en_i        in   auto-gating enable
//   cfg_idle_thr_i  in   idle threshold (thr=N gates after N+1 idle cycles)
//   force_on_i      in   keep the clock running
//   busy_i          in   gated domain has work pending
//   wake_req_i      in   wake request level, held until acknowledged
//   wake_ack_o      out  wake acknowledge (RUN and request high)
//   clk_en_o        out  enable to the clock-gating cell
//   gated_o         out  clock currently gated
//   gate_cnt_o      out  number of RUN->GATED transitions, saturating
// -----------------------------------------------------------------------------
module clk_gate_ctrl #(
  parameter int unsigned IdleCntWidth = 8,
  parameter int unsigned WakeCycles   = 2,
  parameter int unsigned GateCntWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cfg_en_i,
  input  logic [IdleCntWidth-1:0] cfg_idle_thr_i,
  input  logic                    force_on_i,
  input  logic                    busy_i,
  input  logic                    wake_req_i,
  output logic                    wake_ack_o,
  output logic                    clk_en_o,
  output logic                    gated_o,
  output logic [GateCntWidth-1:0] gate_cnt_o
);

  // Encoding 2'b11 is unused; it is treated as RUN by the decode below.
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_GATED = 2'b01,
    ST_WAKE  = 2'b10
  } state_e;

  localparam logic [IdleCntWidth-1:0] IdleZero = {IdleCntWidth{1'b0}};
  localparam logic [IdleCntWidth-1:0] IdleOnes = {IdleCntWidth{1'b1}};
  localparam logic [IdleCntWidth-1:0] IdleOne  = IdleCntWidth'(32'd1);
  localparam logic [GateCntWidth-1:0] GateZero = {GateCntWidth{1'b0}};
  localparam logic [GateCntWidth-1:0] GateOnes = {GateCntWidth{1'b1}};
  localparam logic [GateCntWidth-1:0] GateOne  = GateCntWidth'(32'd1);

  // An out-of-range WakeCycles collapses to a single settle cycle rather than
  // producing a terminal count the 8-bit settle counter can never reach.
  localparam int unsigned WakeLastInt =
      ((WakeCycles >= 32'd1) && (WakeCycles <= 32'd255)) ? (WakeCycles - 32'd1) : 32'd0;
  localparam logic [7:0] WakeLast = 8'(WakeLastInt);

  // Saturating increment of the idle counter.
  function automatic logic [IdleCntWidth-1:0] idle_sat_inc(
    input logic [IdleCntWidth-1:0] val
  );
    logic [IdleCntWidth-1:0] res;
    if (val == IdleOnes) begin
      res = val;
    end else begin
      res = val + IdleOne;
    end
    return res;
  endfunction

  // Saturating increment of the gate-event counter; it never wraps.
  function automatic logic [GateCntWidth-1:0] gate_sat_inc(
    input logic [GateCntWidth-1:0] val
  );
    logic [GateCntWidth-1:0] res;
    if (val == GateOnes) begin
      res = val;
    end else begin
      res = val + GateOne;
    end
    return res;
  endfunction

  state_e                  state_r;
  state_e                  state_s;
  logic [IdleCntWidth-1:0] idle_cnt_r;
  logic [IdleCntWidth-1:0] idle_cnt_s;
  logic [7:0]              settle_cnt_r;
  logic [7:0]              settle_cnt_s;
  logic [GateCntWidth-1:0] gate_cnt_r;
  logic [GateCntWidth-1:0] gate_cnt_s;
  logic                    idle_s;
  logic                    wake_s;

  // Idle qualification: any of busy, force, wake request or disabled
  // auto-gating counts as a reason to keep (or bring back) the clock.
  always_comb begin
    idle_s = cfg_en_i & ~force_on_i & ~busy_i & ~wake_req_i;
    wake_s = ~idle_s;
  end

  // Next-state and counter update logic.
  always_comb begin
    state_s      = state_r;
    idle_cnt_s   = idle_cnt_r;
    settle_cnt_s = settle_cnt_r;
    gate_cnt_s   = gate_cnt_r;
    case (state_r)
      ST_RUN: begin
        // The comparison uses the count before this cycle, so thr=N needs
        // N+1 consecutive idle cycles and the threshold may change on the fly
        // without disturbing the count already accumulated.
        if (idle_s && (idle_cnt_r >= cfg_idle_thr_i)) begin
          state_s    = ST_GATED;
          idle_cnt_s = IdleZero;
          gate_cnt_s = gate_sat_inc(gate_cnt_r);
        end else if (idle_s) begin
          idle_cnt_s = idle_sat_inc(idle_cnt_r);
        end else begin
          idle_cnt_s = IdleZero;
        end
      end
      ST_GATED: begin
        idle_cnt_s = IdleZero;
        if (wake_s) begin
          state_s      = ST_WAKE;
          settle_cnt_s = 8'd0;
        end else begin
          state_s = ST_GATED;
        end
      end
      ST_WAKE: begin
        // Inputs are deliberately ignored here so the settle period is fixed.
        if (settle_cnt_r == WakeLast) begin
          state_s      = ST_RUN;
          idle_cnt_s   = IdleZero;
          settle_cnt_s = 8'd0;
        end else begin
          settle_cnt_s = settle_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s      = ST_RUN;
        idle_cnt_s   = IdleZero;
        settle_cnt_s = 8'd0;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r      <= ST_RUN;
      idle_cnt_r   <= IdleZero;
      settle_cnt_r <= 8'd0;
      gate_cnt_r   <= GateZero;
    end else begin
      state_r      <= state_s;
      idle_cnt_r   <= idle_cnt_s;
      settle_cnt_r <= settle_cnt_s;
      gate_cnt_r   <= gate_cnt_s;
    end
  end

  // Output decode straight from the state register so the gating-cell enable
  // does not depend on any input path; the unused encoding reads as RUN.
  always_comb begin
    clk_en_o   = (state_r != ST_GATED);
    gated_o    = (state_r == ST_GATED);
    wake_ack_o = (state_r == ST_RUN) & wake_req_i;
    gate_cnt_o = gate_cnt_r;
  end

endmodule
